thumb_fetch: RTL and testbench

Instruction fetch unit that feeds the Thumb decode stage: it issues 32-bit word reads to instruction memory, splits each word into two 16-bit Thumb halfwords, buffers them, and presents them one at a time with their PC over a valid/ready handshake. It is the producer side of the decoder's instruction input and also handles branch redirects (flush) from execute.

---
 rtl/thumb_pkg.sv | 19 +
 rtl/hw_fifo.sv | 62 ++++++
 rtl/thumb_fetch.sv | 129 ++++++++++++
 tb/tb_thumb_fetch.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/thumb_pkg.sv
// Shared types and constants for the Thumb instruction fetch path.
package thumb_pkg;

    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_WAIT,
        FETCH_DISCARD
    } fetch_state_e;

    // One buffered Thumb halfword together with its byte address.
    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [HALF_W-1:0] inst;
    } hw_entry_t;

endpackage

// File: rtl/hw_fifo.sv
// Halfword FIFO: up to two pushes (low then high half) and one pop per cycle.
module hw_fifo
    import thumb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_i,
    input  logic                    push_lo_i,
    input  hw_entry_t               lo_i,
    input  logic                    push_hi_i,
    input  hw_entry_t               hi_i,
    input  logic                    pop_i,
    output hw_entry_t               head_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    hw_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] hi_ptr;
    logic [CW-1:0] count_q, count_d;

    // Next pointers and occupancy; the high half lands after the low half when both push.
    always_comb begin
        // NOTE: combinational logic uses blocking '='; only clocked state uses '<='.
        hi_ptr   = wr_ptr_q + AW'(push_lo_i);
        wr_ptr_d = hi_ptr + AW'(push_hi_i);
        rd_ptr_d = rd_ptr_q + AW'(pop_i);
        count_d  = count_q + CW'(push_lo_i) + CW'(push_hi_i) - CW'(pop_i);
    end

    // Entry storage.
    // NOTE: the data array is not reset; occupancy is tracked by the pointers, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push_lo_i) mem_q[wr_ptr_q] <= lo_i;
        if (push_hi_i) mem_q[hi_ptr]   <= hi_i;
    end

    // Pointer and count registers; a clear empties the FIFO regardless of push/pop.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/thumb_fetch.sv
// Thumb fetch unit: word reads from instruction memory, split into halfwords,
// buffered and handed to the decoder over valid/ready, with flush redirect.
module thumb_fetch
    import thumb_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [15:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        flush,
    input  logic [31:0] flush_pc
);

    localparam int          CW          = $clog2(DEPTH) + 1;
    // A request may issue only when both halves of the returning word already fit.
    localparam logic [CW-1:0] ISSUE_MAX = CW'(DEPTH - 2);
    localparam logic [31:0] RESET_WORD  = {RESET_PC[31:2], 2'b00};

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic          skip_lo_q, skip_lo_d;

    logic          push_lo, push_hi, pop;
    hw_entry_t     lo_entry, hi_entry, head;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    // Next-state, memory request and FIFO push control.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        skip_lo_d  = skip_lo_q;
        mem_req    = 1'b0;
        mem_addr   = fetch_pc_q;
        push_lo    = 1'b0;
        push_hi    = 1'b0;

        case (state_q)
            FETCH_IDLE: begin
                if (!flush && (fifo_count <= ISSUE_MAX)) begin
                    mem_req    = 1'b1;
                    req_addr_d = fetch_pc_q;
                    state_d    = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                mem_req  = 1'b1;
                mem_addr = req_addr_q;
                if (flush) begin
                    // An unacked request cannot be withdrawn; its data must be swallowed.
                    state_d = mem_ack ? FETCH_IDLE : FETCH_DISCARD;
                end else if (mem_ack) begin
                    push_lo    = !skip_lo_q;
                    push_hi    = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    skip_lo_d  = 1'b0;
                    state_d    = FETCH_IDLE;
                end
            end
            FETCH_DISCARD: begin
                mem_req  = 1'b1;
                mem_addr = req_addr_q;
                if (mem_ack) state_d = FETCH_IDLE;
            end
            default: state_d = FETCH_IDLE;
        endcase

        if (flush) begin
            fetch_pc_d = flush_pc & 32'hFFFF_FFFC;
            skip_lo_d  = flush_pc[1];
        end

        // The memory is reset together with this unit, so no request is shown during reset.
        if (rst) mem_req = 1'b0;
    end

    // State, PC and request-address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH_IDLE;
            fetch_pc_q <= RESET_WORD;
            req_addr_q <= RESET_WORD;
            skip_lo_q  <= RESET_PC[1];
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            skip_lo_q  <= skip_lo_d;
        end
    end

    assign lo_entry = '{pc: req_addr_q,          inst: mem_rdata[15:0]};
    assign hi_entry = '{pc: req_addr_q + 32'd2,  inst: mem_rdata[31:16]};
    assign pop      = inst_valid && inst_ready && !flush;

    hw_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (flush),
        .push_lo_i (push_lo),
        .lo_i      (lo_entry),
        .push_hi_i (push_hi),
        .hi_i      (hi_entry),
        .pop_i     (pop),
        .head_o    (head),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    // Empty FIFO presents the reset values so the decoder never sees stale storage.
    assign inst_valid = !fifo_empty;
    assign inst       = fifo_empty ? 16'h0000 : head.inst;
    assign inst_pc    = fifo_empty ? RESET_PC : head.pc;

endmodule

// File: tb/tb_thumb_fetch.sv
// Directed bench for thumb_fetch: a cycle table for streaming/backpressure
// plus hand sequences for flush, wrap and reset corner cases.
module tb_thumb_fetch;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic [15:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        flush;
    logic [31:0] flush_pc;

    int n_checks = 0;
    int n_errors = 0;

    thumb_fetch #(
        .RESET_PC(32'h0000_0100),
        .DEPTH   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .inst_valid(inst_valid),
        .inst      (inst),
        .inst_pc   (inst_pc),
        .inst_ready(inst_ready),
        .flush     (flush),
        .flush_pc  (flush_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [15:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(input logic a, input logic [31:0] d, input logic r,
                                input logic q, input logic [31:0] ad,
                                input logic v, input logic [15:0] i, input logic [31:0] p);
        vec_t t;
        t.ack = a; t.rdata = d; t.ready = r;
        t.e_req = q; t.e_addr = ad; t.e_valid = v; t.e_inst = i; t.e_pc = p;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then settle before checking.
    task automatic step(input logic r, input logic a, input logic [31:0] d,
                        input logic rdy, input logic f, input logic [31:0] fp);
        @(negedge clk);
        rst = r; mem_ack = a; mem_rdata = d; inst_ready = rdy; flush = f; flush_pc = fp;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [15:0] e_inst, input logic [31:0] e_pc);
        check({tag, ".mem_req"}, {31'd0, mem_req}, {31'd0, e_req});
        if (e_req) check({tag, ".mem_addr"}, mem_addr, e_addr);
        check({tag, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, e_valid});
        if (e_valid) begin
            check({tag, ".inst"}, {16'd0, inst}, {16'd0, e_inst});
            check({tag, ".inst_pc"}, inst_pc, e_pc);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".mem_req"},    {31'd0, mem_req},    32'd0);
        check({tag, ".mem_addr"},   mem_addr,            32'h0000_0100);
        check({tag, ".inst_valid"}, {31'd0, inst_valid}, 32'd0);
        check({tag, ".inst"},       {16'd0, inst},       32'd0);
        check({tag, ".inst_pc"},    inst_pc,             32'h0000_0100);
    endtask

    initial begin
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0; inst_ready = 1'b0; flush = 1'b0; flush_pc = '0;

        //               ack  rdata         rdy  req  addr          vld  inst     pc
        tbl[0]  = mk(1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0100, 1'b0, 16'h0,    32'h0);
        tbl[1]  = mk(1'b1, 32'hBBBB_AAAA, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 16'h0,    32'h0);
        tbl[2]  = mk(1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0104, 1'b1, 16'hAAAA, 32'h0000_0100);
        tbl[3]  = mk(1'b1, 32'h2222_1111, 1'b1, 1'b1, 32'h0000_0104, 1'b1, 16'hBBBB, 32'h0000_0102);
        tbl[4]  = mk(1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0108, 1'b1, 16'h1111, 32'h0000_0104);
        tbl[5]  = mk(1'b1, 32'h4444_3333, 1'b1, 1'b1, 32'h0000_0108, 1'b1, 16'h2222, 32'h0000_0106);
        tbl[6]  = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_010C, 1'b1, 16'h3333, 32'h0000_0108);
        tbl[7]  = mk(1'b1, 32'h6666_5555, 1'b0, 1'b1, 32'h0000_010C, 1'b1, 16'h3333, 32'h0000_0108);
        tbl[8]  = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 16'h3333, 32'h0000_0108);
        tbl[9]  = mk(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 16'h3333, 32'h0000_0108);
        tbl[10] = mk(1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 16'h3333, 32'h0000_0108);
        tbl[11] = mk(1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 16'h4444, 32'h0000_010A);
        tbl[12] = mk(1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0110, 1'b1, 16'h5555, 32'h0000_010C);
        tbl[13] = mk(1'b1, 32'h8888_7777, 1'b1, 1'b1, 32'h0000_0110, 1'b1, 16'h5555, 32'h0000_010C);
        tbl[14] = mk(1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 16'h6666, 32'h0000_010E);
        tbl[15] = mk(1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0114, 1'b1, 16'h7777, 32'h0000_0110);
        tbl[16] = mk(1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0114, 1'b1, 16'h8888, 32'h0000_0112);
        tbl[17] = mk(1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0114, 1'b0, 16'h0,    32'h0);

        // Reset and streaming with backpressure.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check_reset("reset");
        for (int i = 0; i < 18; i++) begin
            step(1'b0, tbl[i].ack, tbl[i].rdata, tbl[i].ready, 1'b0, 32'h0);
            expect_out($sformatf("tbl%0d", i), tbl[i].e_req, tbl[i].e_addr,
                       tbl[i].e_valid, tbl[i].e_inst, tbl[i].e_pc);
        end

        // Flush to an odd halfword while idle: low half of the first word is dropped.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0206);
        expect_out("fidle0", 1'b0, 32'h0, 1'b0, 16'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        expect_out("fidle1", 1'b1, 32'h0000_0204, 1'b0, 16'h0, 32'h0);
        step(1'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h0);
        expect_out("fidle2", 1'b1, 32'h0000_0204, 1'b0, 16'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        expect_out("fidle3", 1'b1, 32'h0000_0208, 1'b1, 16'h1234, 32'h0000_0206);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        expect_out("fidle4", 1'b1, 32'h0000_0208, 1'b0, 16'h0, 32'h0);

        // Flush while waiting: old request held, late data discarded, then new target.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0300);
        expect_out("fwait0", 1'b1, 32'h0000_0208, 1'b0, 16'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        expect_out("fwait1", 1'b1, 32'h0000_0208, 1'b0, 16'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        expect_out("fwait2", 1'b1, 32'h0000_0208, 1'b0, 16'h0, 32'h0);
        step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
        expect_out("fwait3", 1'b1, 32'h0000_0208, 1'b0, 16'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        expect_out("fwait4", 1'b1, 32'h0000_0300, 1'b0, 16'h0, 32'h0);
        step(1'b0, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0);
        expect_out("fwait5", 1'b1, 32'h0000_0300, 1'b0, 16'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        expect_out("fwait6", 1'b1, 32'h0000_0304, 1'b1, 16'hF00D, 32'h0000_0300);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        expect_out("fwait7", 1'b1, 32'h0000_0304, 1'b1, 16'hCAFE, 32'h0000_0302);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        expect_out("fwait8", 1'b1, 32'h0000_0304, 1'b0, 16'h0, 32'h0);

        // Flush together with ack and a transfer: data dropped, new request next cycle.
        step(1'b0, 1'b1, 32'h2222_1111, 1'b0, 1'b0, 32'h0);
        expect_out("fack0", 1'b1, 32'h0000_0304, 1'b0, 16'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("fack1", 1'b1, 32'h0000_0308, 1'b1, 16'h1111, 32'h0000_0304);
        step(1'b0, 1'b1, 32'h5555_6666, 1'b1, 1'b1, 32'h0000_0400);
        expect_out("fack2", 1'b1, 32'h0000_0308, 1'b1, 16'h1111, 32'h0000_0304);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("fack3", 1'b1, 32'h0000_0400, 1'b0, 16'h0, 32'h0);
        step(1'b0, 1'b1, 32'h7777_8888, 1'b0, 1'b0, 32'h0);
        expect_out("fack4", 1'b1, 32'h0000_0400, 1'b0, 16'h0, 32'h0);

        // Flush in idle with data buffered (no same-cycle request), then PC wrap.
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        expect_out("wrap0", 1'b0, 32'h0, 1'b1, 16'h8888, 32'h0000_0400);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("wrap1", 1'b1, 32'hFFFF_FFFC, 1'b0, 16'h0, 32'h0);
        step(1'b0, 1'b1, 32'hABCD_0123, 1'b0, 1'b0, 32'h0);
        expect_out("wrap2", 1'b1, 32'hFFFF_FFFC, 1'b0, 16'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        expect_out("wrap3", 1'b1, 32'h0000_0000, 1'b1, 16'h0123, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("wrap4", 1'b1, 32'h0000_0000, 1'b1, 16'hABCD, 32'hFFFF_FFFE);

        // Reset while waiting with a buffered halfword.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check_reset("midrst");
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_out("postrst", 1'b1, 32'h0000_0100, 1'b0, 16'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
